// File: rtl/return_address_stack_if.sv
// Control-unit <-> return-address-stack bundle: CALL/RET commit strobes in, top-of-stack and status out.
interface return_address_stack_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 4
);
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] push_addr;
  logic              clear_err;
  logic [ADDR_W-1:0] top_address;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;
  logic              overflow_err;
  logic              underflow_err;

  modport master (
    output push, pop, push_addr, clear_err,
    input  top_address, count, empty, full, overflow_err, underflow_err
  );

  modport slave (
    input  push, pop, push_addr, clear_err,
    output top_address, count, empty, full, overflow_err, underflow_err
  );
endinterface

// File: rtl/return_address_stack.sv
// Return-address stack for CALL/RET. Define RAS_WRAP_EN to make push-while-full
// overwrite the oldest entry (circular storage); otherwise such a push is dropped.
module return_address_stack #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  return_address_stack_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  base_ptr, wr_idx, top_idx, mem_idx;
  logic              ovf_q, unf_q;
  logic              ovf_set, unf_set;
  logic              is_empty, is_full;
  logic              push_pop, push_only, pop_only;
  logic              mem_we;

  assign push_pop  = bus.push & bus.pop;
  assign push_only = bus.push & ~bus.pop;
  assign pop_only  = bus.pop & ~bus.push;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CNT_W'(DEPTH));

  // Slot above the top; equals base_ptr when full since count[PTR_W-1:0] wraps to 0.
  assign wr_idx  = base_ptr + count_q[PTR_W-1:0];
  assign top_idx = wr_idx - PTR_W'(1);

`ifdef RAS_WRAP_EN
  logic base_adv;
  assign base_adv = push_only & is_full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_ptr <= '0;
    end else if (base_adv) begin
      base_ptr <= base_ptr + PTR_W'(1);
    end
  end
`else
  assign base_ptr = '0;
`endif

  always_comb begin
    count_d = count_q;
    mem_we  = 1'b0;
    mem_idx = wr_idx;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (push_pop) begin
      mem_we = 1'b1;
      if (is_empty) begin
        count_d = count_q + CNT_W'(1);
      end else begin
        mem_idx = top_idx;
      end
    end else if (push_only) begin
      if (!is_full) begin
        mem_we  = 1'b1;
        count_d = count_q + CNT_W'(1);
      end else begin
        ovf_set = 1'b1;
`ifdef RAS_WRAP_EN
        mem_we  = 1'b1;
`endif
      end
    end else if (pop_only) begin
      if (!is_empty) begin
        count_d = count_q - CNT_W'(1);
      end else begin
        unf_set = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      // A new error in the same cycle as clear_err keeps the flag set.
      ovf_q   <= ovf_set | (ovf_q & ~bus.clear_err);
      unf_q   <= unf_set | (unf_q & ~bus.clear_err);
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_idx] <= bus.push_addr;
    end
  end

  assign bus.top_address   = is_empty ? '0 : mem[top_idx];
  assign bus.count         = count_q;
  assign bus.empty         = is_empty;
  assign bus.full          = is_full;
  assign bus.overflow_err  = ovf_q;
  assign bus.underflow_err = unf_q;
endmodule
